// File: rtl/cpu_step_controller_pkg.sv
// Shared definitions for the CPU step controller: run-mode encodings and defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_step_controller_pkg;

  // Encoding is visible on the mode output, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, rising-edge press pulse.
// Latency: a raw edge stable for DEBOUNCE_CYCLES samples yields btn_press 2+DEBOUNCE_CYCLES+1 clks later.
// Backpressure: none; btn_press is a single-clk pulse per accepted press, holding gives one pulse.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset, clears synchroniser, counter and accepted level
//   btn_raw   raw asynchronous button level
//   btn_press one-clk pulse on each accepted rising level
module button_debounce
  import cpu_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_press
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncMeta;
  logic          syncLevel;
  logic          level;
  logic          levelDly;
  logic [CW-1:0] stableCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta  <= 1'b0;
      syncLevel <= 1'b0;
      level     <= 1'b0;
      levelDly  <= 1'b0;
      stableCnt <= '0;
      btn_press <= 1'b0;
    end else begin
      syncMeta  <= btn_raw;
      syncLevel <= syncMeta;

      // stableCnt counts consecutive samples that disagree with the accepted
      // level; any agreeing sample (a bounce back) restarts the count.
      if (syncLevel == level) begin
        stableCnt <= '0;
      end else if (stableCnt == LAST) begin
        level     <= syncLevel;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + CW'(1);
      end

      levelDly  <= level;
      btn_press <= level & ~levelDly;
    end
  end

endmodule

// File: rtl/cpu_step_controller.sv
// Turns the divider tick into the MIPS datapath instruction enable under run/step/halt control.
// Latency: cpu_en is combinational from tick_in (zero latency); mode updates one clk after a press pulse.
// Backpressure: none; every tick in RUN/STEP yields exactly one enable, ticks in other modes are dropped.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick_in      one-clk enable pulse from the divider stage
//   run_btn      raw run/pause push-button
//   step_btn     raw single-step push-button
//   halt_in      core halt/exit level; parks the controller in HALTED until reset
//   cpu_en       datapath instruction enable
//   instr_count  number of cycles in which cpu_en was high (wraps silently)
//   mode         registered state encoding (IDLE/RUN/STEP/HALTED)
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       mode
);

  mode_t state;
  mode_t stateNext;
  logic  runPress;
  logic  stepPress;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) runDebounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (run_btn),
    .btn_press (runPress)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) stepDebounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (step_btn),
    .btn_press (stepPress)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    // Enable uses the current state, so a pause landing on a tick cycle
    // still lets that tick through; the new state applies next cycle.
    cpu_en    = tick_in & ((state == RUN) | (state == STEP)) & ~halt_in & ~rst;

    if (state != HALTED && halt_in) begin
      stateNext = HALTED;
    end else begin
      case (state)
        IDLE: begin
          // Run has priority over a simultaneous step press.
          if (runPress) begin
            stateNext = RUN;
          end else if (stepPress) begin
            stateNext = STEP;
          end
        end
        RUN: begin
          if (runPress) begin
            stateNext = IDLE;
          end
        end
        STEP: begin
          // Leave on the tick that was just enabled; presses are ignored here.
          if (tick_in) begin
            stateNext = IDLE;
          end
        end
        HALTED: begin
          stateNext = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if (cpu_en) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_cpu_step_controller.sv
module tb_cpu_step_controller;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       run_btn;
  logic       step_btn;
  logic       halt_in;
  logic       cpu_en;
  logic [3:0] instr_count;
  logic [1:0] mode;

  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_in     (halt_in),
    .cpu_en      (cpu_en),
    .instr_count (instr_count),
    .mode        (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checkCnt = 0;
  int         errorCnt = 0;
  int         phase    = 0;
  int         pushes   = 0;
  bit         ticksOn  = 0;
  bit         expEnable = 0;
  bit         stepOnce = 0;
  bit         haltLvl  = 0;
  bit         expNow   = 0;
  logic [3:0] expCount = 4'd0;
  logic [3:0] expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errorCnt++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: tick every 4th cycle when enabled; expected enables go to the scoreboard.
  task automatic clkCycle();
    @(posedge clk);
    #1;
    phase   = (phase + 1) % 4;
    tick_in = ticksOn && (phase == 0);
    halt_in = haltLvl;
    expNow  = tick_in && expEnable;
    if (expNow) begin
      expQ.push_back(expCount);
      expCount = expCount + 4'd1;
      pushes++;
      if (stepOnce) expEnable = 0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) clkCycle();
  endtask

  task automatic alignPhase(input int p);
    for (int i = 0; i < 4 && phase != p; i++) clkCycle();
  endtask

  task automatic runTicks(input int target);
    for (int i = 0; i < 200 && pushes < target; i++) clkCycle();
    if (pushes < target) checkVal("tick_budget", pushes, target);
    clkCycle();
  endtask

  // Scoreboard side: every cycle cpu_en must match the expectation, and each
  // enable pops the count value the bench predicted for it.
  always @(negedge clk) begin
    checkVal("cpu_en", cpu_en, expNow);
    if (cpu_en) begin
      checkVal("en_tick", tick_in, 1);
      if (expQ.size() == 0) checkVal("en_unexpected", cpu_en, 0);
      else checkVal("en_cnt", instr_count, expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; tick_in = 0; run_btn = 0; step_btn = 0; halt_in = 0;

    // Reset with tick toggling: no enable.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tick_in = (i % 2 == 0);
    end
    @(posedge clk); #1;
    rst = 0; tick_in = 0; phase = 0;
    @(negedge clk);
    checkVal("rst_mode", mode, 0);
    checkVal("rst_cnt", instr_count, 0);

    // Bouncing run press, final edge then held.
    run_btn = 1; clkCycle();
    run_btn = 0; clkCycle();
    run_btn = 1;
    cycles(7);
    @(negedge clk); checkVal("run_lat7", mode, 0);
    clkCycle();
    @(negedge clk); checkVal("run_lat8", mode, 1);

    // Free run, 10 ticks.
    ticksOn = 1; expEnable = 1;
    cycles(40);
    ticksOn = 0;
    clkCycle();
    @(negedge clk);
    checkVal("free_cnt", instr_count, 10);
    checkVal("free_mode", mode, 1);

    // Pause whose press pulse lands on a tick cycle: that tick still enables.
    run_btn = 0;
    cycles(10);
    alignPhase(1);
    ticksOn = 1;
    run_btn = 1;
    cycles(7);
    expEnable = 0;
    clkCycle();
    @(negedge clk); checkVal("pause_mode", mode, 0);
    cycles(12);
    @(negedge clk); checkVal("pause_cnt", instr_count, 12);

    // Single step, second press mid-STEP ignored.
    ticksOn = 0; run_btn = 0;
    cycles(10);
    step_btn = 1;
    cycles(8);
    @(negedge clk); checkVal("step_enter", mode, 2);
    step_btn = 0; cycles(10);
    step_btn = 1; cycles(10);
    step_btn = 0; cycles(10);
    @(negedge clk); checkVal("step_hold", mode, 2);
    stepOnce = 1; expEnable = 1; ticksOn = 1;
    cycles(4);
    cycles(12);
    @(negedge clk);
    checkVal("step_exit", mode, 0);
    checkVal("step_cnt", instr_count, 13);
    stepOnce = 0; expEnable = 0;

    // Simultaneous run and step press in IDLE: run wins.
    ticksOn = 0;
    run_btn = 1; step_btn = 1;
    cycles(8);
    @(negedge clk); checkVal("both_mode", mode, 1);

    // Halt coinciding with a tick in RUN.
    alignPhase(3);
    ticksOn = 1; haltLvl = 1;
    clkCycle();
    @(negedge clk); checkVal("halt_en", cpu_en, 0);
    haltLvl = 0;
    clkCycle();
    @(negedge clk);
    checkVal("halt_mode", mode, 3);
    checkVal("halt_cnt", instr_count, 13);
    run_btn = 0; step_btn = 0; cycles(10);
    run_btn = 1; step_btn = 1; cycles(10);
    run_btn = 0; step_btn = 0; cycles(20);
    @(negedge clk);
    checkVal("halt_sticky", mode, 3);
    checkVal("halt_cnt2", instr_count, 13);

    // Reset out of HALTED.
    rst = 1; clkCycle(); rst = 0;
    @(negedge clk);
    checkVal("rst2_mode", mode, 0);
    checkVal("rst2_cnt", instr_count, 0);
    expCount = 4'd0;

    // Counter wrap with a 4-bit counter.
    ticksOn = 0;
    run_btn = 1;
    cycles(8);
    @(negedge clk); checkVal("wrap_run", mode, 1);
    pushes = 0; expEnable = 1; ticksOn = 1;
    runTicks(15);
    @(negedge clk); checkVal("wrap15", instr_count, 15);
    runTicks(16);
    @(negedge clk); checkVal("wrap16", instr_count, 0);
    runTicks(17);
    @(negedge clk); checkVal("wrap17", instr_count, 1);

    // Reset mid-RUN on a tick cycle: no enable, back to IDLE.
    alignPhase(3);
    expEnable = 0;
    clkCycle();
    rst = 1;
    @(negedge clk); checkVal("rst_run_en", cpu_en, 0);
    clkCycle();
    rst = 0;
    @(negedge clk);
    checkVal("rst_run_mode", mode, 0);
    checkVal("rst_run_cnt", instr_count, 0);

    checkVal("q_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
    $finish;
  end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Consumes the one-in-four tick produced by the 32-bit counter/clock-divider stage.
- Turns that tick into the per-instruction enable for the MIPS datapath.
- Supports three run modes: free-run, single-step (one instruction per button press) and halted.
- Debounces the board run/step buttons and keeps a retired-instruction counter for the display logic.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable clk samples required before a button level is accepted.
- CNT_W, 32: width of instr_count.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  one-cycle enable pulse from the divider stage.
- run_btn  input  1  raw, asynchronous run/pause push-button.
- step_btn  input  1  raw, asynchronous single-step push-button.
- halt_in  input  1  core reports a halt/syscall-exit; level.
- cpu_en  output  1  datapath instruction enable.
- instr_count  output  CNT_W  number of cycles in which cpu_en was high.
- mode  output  2  current FSM state encoding.

Behaviour:
- Reset (rst=1 at posedge):
  - mode=IDLE, instr_count=0, synchronisers and debounce counters cleared.
  - cpu_en=0 during any cycle in which rst=1, even if tick_in=1.
- Button path, each button:
  - 2-FF synchroniser feeds the debouncer.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the accepted level produces a one-clk press pulse (run_press, step_press).
  - Holding a button produces exactly one pulse.
  - Latency from a stable raw edge to the pulse: 2 + DEBOUNCE_CYCLES + 1 clks.
- States: IDLE=2'd0, RUN=2'd1, STEP=2'd2, HALTED=2'd3. mode is the registered state.
- Transitions, evaluated at posedge, in priority order:
  - rst → IDLE.
  - HALTED: stays HALTED; only rst exits.
  - halt_in=1 in any other state → HALTED.
  - IDLE: run_press → RUN; else step_press → STEP. Simultaneous run_press and step_press: RUN wins.
  - RUN: run_press → IDLE (pause); step_press ignored.
  - STEP: on the cycle where tick_in=1 → IDLE. Press pulses are ignored while in STEP.
- cpu_en:
  - Combinational: cpu_en = tick_in & (mode==RUN | mode==STEP) & ~halt_in & ~rst.
  - Zero latency from tick_in; exactly one enable per tick.
  - STEP yields exactly one enable, on the first tick after entry.
  - A pause request taking effect at a posedge still lets a tick in that same cycle enable. The new state applies from the next cycle.
- instr_count:
  - Increments by 1 at each posedge where cpu_en=1.
  - Wraps from 2^CNT_W−1 to 0 silently.
  - Holds in every other cycle, including HALTED.
- halt_in=1 coinciding with tick_in in RUN/STEP: no enable, no count increment, next state HALTED.
- rst asserted mid-RUN or mid-STEP: the pending step is discarded; the controller returns to IDLE the next cycle.

Decomposition:
- Shared package holds the mode encodings (IDLE/RUN/STEP/HALTED) and the default DEBOUNCE_CYCLES.
- Sub-module button_debounce: synchroniser, debounce counter and rising-edge pulse. Parameterised by DEBOUNCE_CYCLES, with ports clk, rst, btn_raw, btn_press.
- button_debounce is instantiated twice.
- FSM, enable gating and counter live in the top.

Test Plan (DEBOUNCE_CYCLES=4, tick_in every 4th clk as the divider produces):
- Reset and bounce:
  - Assert rst for 3 clks with tick_in toggling → cpu_en=0 throughout; mode=0 and instr_count=0 after release.
  - Toggle run_btn 1-0-1 at 1-clk spacing, then hold it high → exactly one run_press, 7 clks after the final stable edge; mode=1.
- Free run: in RUN for 40 clks (10 ticks) → cpu_en pulses 10 times, aligned with tick_in; instr_count=10. Press run again → mode=0 and count holds at 10.
- Single step: from IDLE press step once → mode=2 until the next tick. cpu_en is high for exactly that tick, then mode=0 and instr_count increments by 1. A second press mid-STEP gives no extra enable.
- Simultaneous events:
  - run_press and step_press in the same IDLE cycle → mode=1.
  - halt_in=1 coinciding with a tick in RUN → cpu_en=0, count unchanged, mode=3.
  - Further button presses keep mode=3 until rst.
- Wrap: with CNT_W=4, run 17 ticks from reset → instr_count reads 15 after 15 ticks, 0 after 16, 1 after 17.
